jtag_scan_sequencer: RTL

//   Host-side JTAG master controller. Takes IR/DR scan commands over a valid/ready

---
 rtl/jtag_scan_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_sequencer.sv
// JTAG master: walks the target TAP through IR/DR scans issued on a valid/ready
// command channel and returns the captured TDO bits on a response channel.
//
// state    | meaning
// RST_WALK | 5 TCK with TMS=1 (Test-Logic-Reset), 1 TCK with TMS=0 (Run-Test/Idle)
// IDLE     | parked in Run-Test/Idle, tck low, waiting for a command
// SEL      | Select/Capture path into Shift-DR or Shift-IR
// SHIFT    | one TCK per bit, last bit moves the TAP to Exit1
// EXIT     | Update, then back to Run-Test/Idle
// RESP     | result presented until the host consumes it
module jtag_scan_sequencer #(
  parameter int DATA_W = 32,
  parameter int CLK_DIV = 4,
  localparam int LEN_W = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              busy
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int STEP_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_RST_WALK = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_SEL      = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_EXIT     = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  logic [2:0]        state;
  logic [STEP_W-1:0] step;
  logic [DIV_W-1:0]  div_cnt;
  logic              ir_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cap;

  logic              running;
  logic              tc;
  logic              rise;
  logic              fall;
  logic [STEP_W-1:0] step_nxt;
  logic [STEP_W-1:0] last_bit;
  logic [STEP_W-1:0] sel_last;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [LEN_W-1:0]  len_eff;

  assign running  = (state == ST_RST_WALK) || (state == ST_SEL) ||
                    (state == ST_SHIFT) || (state == ST_EXIT);
  // div_cnt is a down-counter; terminal count toggles tck
  assign tc       = (div_cnt == '0);
  assign rise     = running && tc && !tck;
  assign fall     = running && tc && tck;
  assign step_nxt = step + STEP_W'(1);
  assign last_bit = STEP_W'(len_q) - STEP_W'(1);
  assign sel_last = ir_q ? STEP_W'(3) : STEP_W'(2);
  assign idx      = step[IDX_W-1:0];
  assign idx_nxt  = step_nxt[IDX_W-1:0];
  assign len_eff  = ((cmd_len == '0) || (cmd_len > LEN_W'(DATA_W))) ? LEN_W'(DATA_W) : cmd_len;

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RST_WALK;
      step      <= '0;
      div_cnt   <= DIV_MAX;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      ir_q      <= 1'b0;
      len_q     <= '0;
      data_q    <= '0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (running) begin
        if (tc) begin
          div_cnt <= DIV_MAX;
          tck     <= ~tck;
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end

      if (rise && (state == ST_SHIFT)) cap[idx] <= tdo;

      // every transition below happens on a tck falling edge, i.e. at a TCK cycle start
      case (state)
        ST_RST_WALK: begin
          if (fall) begin
            if (step == STEP_W'(5)) begin
              state <= ST_IDLE;
              step  <= '0;
            end else begin
              step <= step_nxt;
              tms  <= (step < STEP_W'(4));
            end
          end
        end
        ST_IDLE: begin
          tms <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            ir_q    <= cmd_ir;
            len_q   <= len_eff;
            data_q  <= cmd_data;
            cap     <= '0;
            step    <= '0;
            div_cnt <= DIV_MAX;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            state   <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (fall) begin
            if (step == sel_last) begin
              state <= ST_SHIFT;
              step  <= '0;
              tms   <= (len_q == LEN_W'(1));
              tdi   <= data_q[0];
            end else begin
              step <= step_nxt;
              tms  <= ir_q && (step == '0);
            end
          end
        end
        ST_SHIFT: begin
          if (fall) begin
            if (step == last_bit) begin
              state <= ST_EXIT;
              step  <= '0;
              tms   <= 1'b1;
              tdi   <= 1'b0;
            end else begin
              step <= step_nxt;
              tdi  <= data_q[idx_nxt];
              tms  <= (step_nxt == last_bit);
            end
          end
        end
        ST_EXIT: begin
          if (fall) begin
            if (step == '0) begin
              step <= step_nxt;
              tms  <= 1'b0;
            end else begin
              state <= ST_RESP;
              step  <= '0;
            end
          end
        end
        ST_RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_RST_WALK;
      endcase
    end
  end

endmodule
